program_counter: RTL and testbench

- Architectural program-counter register of the 16-bit single-cycle CPU.
- Captures the next-PC value, computed upstream by the PC+1 / branch / jump mux, on every rising clock edge.
- Presents the current PC to instruction memory and the next-PC logic.
- Purely sequential; no arithmetic inside the block.

---
 rtl/cpu_pkg.sv | 11 +
 rtl/program_counter.sv | 41 ++++
 tb/tb_program_counter.sv | 124 ++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit single-cycle CPU.
// Holds the PC width, the boot vector and the PC type.
package cpu_pkg;

    localparam int PC_WIDTH = 16;

    typedef logic [PC_WIDTH-1:0] pc_t;

    localparam pc_t RESET_VECTOR = 16'h0000;

endpackage

// File: rtl/program_counter.sv
// Architectural PC register: captures next-PC every rising edge.
// Optional hold input enabled by defining PC_STALL_EN.
module program_counter
    import cpu_pkg::*;
#(
    parameter int WIDTH = PC_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VALUE = RESET_VECTOR
) (
    input  logic             clk,
    input  logic             reset,
`ifdef PC_STALL_EN
    input  logic             stall,
`endif
    input  logic [WIDTH-1:0] PC_In,
    output logic [WIDTH-1:0] PC_output
);

    logic [WIDTH-1:0] pc_q;

    // PC register: async boot-vector load, otherwise take next-PC
`ifdef PC_STALL_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q <= RESET_VALUE;
        end else if (!stall) begin
            pc_q <= PC_In;
        end
    end
`else
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q <= RESET_VALUE;
        end else begin
            pc_q <= PC_In;
        end
    end
`endif

    assign PC_output = pc_q;

endmodule

// File: tb/tb_program_counter.sv
// Self-checking bench for program_counter.
// Directed test-plan steps followed by random next-PC/reset/stall traffic.
module tb_program_counter;
    import cpu_pkg::*;

`ifdef PC_STALL_EN
    localparam bit STALL_ON = 1'b1;
`else
    localparam bit STALL_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    logic stall;
    pc_t  pc_in;
    pc_t  pc_output;

    int   checks = 0;
    int   errors = 0;
    pc_t  exp_pc;

    always #5 clk = ~clk;

    program_counter dut (
        .clk       (clk),
        .reset     (reset),
`ifdef PC_STALL_EN
        .stall     (stall),
`endif
        .PC_In     (pc_in),
        .PC_output (pc_output)
    );

    task automatic check(input string tag, input pc_t obs, input pc_t exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive at negedge, check before and after the edge.
    task automatic cycle(input pc_t next, input bit st, input bit rst);
        @(negedge clk);
        pc_in = next;
        stall = st;
        reset = rst;
        if (!rst) exp_pc = RESET_VECTOR;
        #1;
        check("pre_edge", pc_output, exp_pc);
        if (!rst)
            exp_pc = RESET_VECTOR;
        else if (!(STALL_ON && st))
            exp_pc = next;
        @(posedge clk);
        #1;
        check("post_edge", pc_output, exp_pc);
    endtask

    initial begin
        pc_t r;
        bit  rs;
        bit  ss;

        reset = 1'b0;
        stall = 1'b0;
        pc_in = 'x;
        exp_pc = RESET_VECTOR;
        @(posedge clk);
        #1;
        check("reset_hold", pc_output, 16'h0000);
        @(posedge clk);
        #1;
        check("reset_hold2", pc_output, 16'h0000);

        cycle(16'h1234, 1'b0, 1'b1);
        check("load_1234", pc_output, 16'h1234);
        cycle(16'h5678, 1'b0, 1'b1);
        check("load_5678", pc_output, 16'h5678);

        // Asynchronous assertion between edges
        @(negedge clk);
        #2;
        reset = 1'b0;
        pc_in = 16'h9ABC;
        #1;
        check("async_reset", pc_output, 16'h0000);
        exp_pc = RESET_VECTOR;
        cycle(16'h9ABC, 1'b0, 1'b0);
        cycle(16'h9ABC, 1'b0, 1'b0);
        check("reset_stays", pc_output, 16'h0000);

        cycle(16'hFFFF, 1'b0, 1'b1);
        check("max_value", pc_output, 16'hFFFF);
        cycle(16'h0000, 1'b0, 1'b1);
        check("zero_value", pc_output, 16'h0000);

`ifdef PC_STALL_EN
        cycle(16'h1234, 1'b0, 1'b1);
        cycle(16'h5678, 1'b1, 1'b1);
        check("stall_hold", pc_output, 16'h1234);
        cycle(16'h5678, 1'b0, 1'b1);
        check("stall_release", pc_output, 16'h5678);
        cycle(16'hABCD, 1'b1, 1'b0);
        check("reset_over_stall", pc_output, 16'h0000);
`endif

        for (int i = 0; i < 300; i++) begin
            r = pc_t'($urandom);
            case ($urandom_range(0, 7))
                0: r = 16'hFFFF;
                1: r = 16'h0000;
                default: ;
            endcase
            rs = ($urandom_range(0, 7) != 0);
            ss = ($urandom_range(0, 3) == 0);
            cycle(r, ss, rs);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
